// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundles the ID-stage inputs and the EX-stage outputs of the ID/EX pipeline
// register. The ID stage (or a testbench) is the master: it drives id_* and
// observes ex_* and the load-use hazard flag. The pipeline register is the
// slave.
//   id_valid_i        ID stage holds a real instruction
//   id_wb_ctrl_i      write-back control
//   id_m_ctrl_i       memory control, [1]=MemRead [0]=MemWrite
//   id_ex_ctrl_i      [0]=RegDst [2:1]=AluOp [3]=AluSrc
//   id_branch_i       branch flag
//   id_pc4_i/rd1/rd2/imm   datapath words
//   id_rs/rt/rt_extra/rd   register specifiers
//   ex_*              registered EX-stage copies of the above
//   load_use_hazard_o combinational load-use stall request
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 6,
  parameter int WB_W    = 2,
  parameter int M_W     = 2
);
  logic              id_valid_i;
  logic [WB_W-1:0]   id_wb_ctrl_i;
  logic [M_W-1:0]    id_m_ctrl_i;
  logic [3:0]        id_ex_ctrl_i;
  logic              id_branch_i;
  logic [DATA_W-1:0] id_pc4_i;
  logic [DATA_W-1:0] id_rd1_i;
  logic [DATA_W-1:0] id_rd2_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rt_extra_i;
  logic [REG_AW-1:0] id_rd_i;

  logic               ex_valid_o;
  logic [WB_W-1:0]    ex_wb_ctrl_o;
  logic [M_W-1:0]     ex_m_ctrl_o;
  logic               ex_reg_dst_o;
  logic               ex_alu_src_o;
  logic               ex_branch_o;
  logic [1:0]         ex_alu_op_o;
  logic [FUNCT_W-1:0] ex_funct_o;
  logic [DATA_W-1:0]  ex_pc4_o;
  logic [DATA_W-1:0]  ex_rd1_o;
  logic [DATA_W-1:0]  ex_rd2_o;
  logic [DATA_W-1:0]  ex_imm_o;
  logic [REG_AW-1:0]  ex_rs_o;
  logic [REG_AW-1:0]  ex_rt_o;
  logic [REG_AW-1:0]  ex_rt_extra_o;
  logic [REG_AW-1:0]  ex_rd_o;

  logic               load_use_hazard_o;

  modport master (
    output id_valid_i, id_wb_ctrl_i, id_m_ctrl_i, id_ex_ctrl_i, id_branch_i,
           id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i,
           id_rs_i, id_rt_i, id_rt_extra_i, id_rd_i,
    input  ex_valid_o, ex_wb_ctrl_o, ex_m_ctrl_o, ex_reg_dst_o, ex_alu_src_o,
           ex_branch_o, ex_alu_op_o, ex_funct_o,
           ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
           ex_rs_o, ex_rt_o, ex_rt_extra_o, ex_rd_o,
           load_use_hazard_o
  );

  modport slave (
    input  id_valid_i, id_wb_ctrl_i, id_m_ctrl_i, id_ex_ctrl_i, id_branch_i,
           id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i,
           id_rs_i, id_rt_i, id_rt_extra_i, id_rd_i,
    output ex_valid_o, ex_wb_ctrl_o, ex_m_ctrl_o, ex_reg_dst_o, ex_alu_src_o,
           ex_branch_o, ex_alu_op_o, ex_funct_o,
           ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
           ex_rs_o, ex_rt_o, ex_rt_extra_o, ex_rd_o,
           load_use_hazard_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register for the 5-stage MIPS core with a valid bit,
// stall (hold), flush (bubble), integrated load-use hazard detection and a
// saturating bubble counter.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall_i      hold the EX entry
//   flush_i      write a bubble (overrides stall)
//   cnt_clr_i    synchronous clear of the bubble counter
//   bus          ID inputs / EX outputs / hazard flag (slave side)
//   bubble_cnt_o bubbles written since reset or last clear (saturating)
// Update priority per edge: flush > stall > hazard > load.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 6,
  parameter int WB_W    = 2,
  parameter int M_W     = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                cnt_clr_i,
  id_ex_pipe_reg_if.slave     bus,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  logic               valid_q,    valid_d;
  logic [WB_W-1:0]    wb_ctrl_q,  wb_ctrl_d;
  logic [M_W-1:0]     m_ctrl_q,   m_ctrl_d;
  logic               reg_dst_q,  reg_dst_d;
  logic               alu_src_q,  alu_src_d;
  logic               branch_q,   branch_d;
  logic [1:0]         alu_op_q,   alu_op_d;
  logic [FUNCT_W-1:0] funct_q,    funct_d;
  logic [DATA_W-1:0]  pc4_q,      pc4_d;
  logic [DATA_W-1:0]  rd1_q,      rd1_d;
  logic [DATA_W-1:0]  rd2_q,      rd2_d;
  logic [DATA_W-1:0]  imm_q,      imm_d;
  logic [REG_AW-1:0]  rs_q,       rs_d;
  logic [REG_AW-1:0]  rt_q,       rt_d;
  logic [REG_AW-1:0]  rt_extra_q, rt_extra_d;
  logic [REG_AW-1:0]  rd_q,       rd_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  logic hazard;
  logic bubble;
  logic load;

  // A load in EX whose destination feeds the ID instruction; $zero is never
  // a real dependency. Independent of stall/flush by design.
  assign hazard = bus.id_valid_i & valid_q & m_ctrl_q[1] & (rt_q != '0) &
                  ((rt_q == bus.id_rs_i) | (rt_q == bus.id_rt_i));

  // Stall masks the hazard bubble because the EX entry is unchanged and the
  // hazard simply re-evaluates once the stall releases.
  assign bubble = flush_i | (hazard & ~stall_i);
  assign load   = ~flush_i & ~stall_i & ~hazard;

  always_comb begin
    valid_d    = valid_q;
    wb_ctrl_d  = wb_ctrl_q;
    m_ctrl_d   = m_ctrl_q;
    reg_dst_d  = reg_dst_q;
    alu_src_d  = alu_src_q;
    branch_d   = branch_q;
    alu_op_d   = alu_op_q;
    funct_d    = funct_q;
    pc4_d      = pc4_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rt_extra_d = rt_extra_q;
    rd_d       = rd_q;

    if (bubble) begin
      // Bubble kills control only; datapath fields hold to save toggling.
      valid_d   = 1'b0;
      wb_ctrl_d = '0;
      m_ctrl_d  = '0;
      reg_dst_d = 1'b0;
      alu_src_d = 1'b0;
      branch_d  = 1'b0;
      alu_op_d  = '0;
    end else if (load) begin
      valid_d    = bus.id_valid_i;
      wb_ctrl_d  = bus.id_wb_ctrl_i;
      m_ctrl_d   = bus.id_m_ctrl_i;
      reg_dst_d  = bus.id_ex_ctrl_i[0];
      alu_op_d   = bus.id_ex_ctrl_i[2:1];
      alu_src_d  = bus.id_ex_ctrl_i[3];
      branch_d   = bus.id_branch_i;
      funct_d    = bus.id_imm_i[FUNCT_W-1:0];
      pc4_d      = bus.id_pc4_i;
      rd1_d      = bus.id_rd1_i;
      rd2_d      = bus.id_rd2_i;
      imm_d      = bus.id_imm_i;
      rs_d       = bus.id_rs_i;
      rt_d       = bus.id_rt_i;
      rt_extra_d = bus.id_rt_extra_i;
      rd_d       = bus.id_rd_i;
    end
  end

  // Saturating bubble counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wb_ctrl_q  <= '0;
      m_ctrl_q   <= '0;
      reg_dst_q  <= 1'b0;
      alu_src_q  <= 1'b0;
      branch_q   <= 1'b0;
      alu_op_q   <= '0;
      funct_q    <= '0;
      pc4_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rt_extra_q <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      wb_ctrl_q  <= wb_ctrl_d;
      m_ctrl_q   <= m_ctrl_d;
      reg_dst_q  <= reg_dst_d;
      alu_src_q  <= alu_src_d;
      branch_q   <= branch_d;
      alu_op_q   <= alu_op_d;
      funct_q    <= funct_d;
      pc4_q      <= pc4_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rt_extra_q <= rt_extra_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid_o        = valid_q;
  assign bus.ex_wb_ctrl_o      = wb_ctrl_q;
  assign bus.ex_m_ctrl_o       = m_ctrl_q;
  assign bus.ex_reg_dst_o      = reg_dst_q;
  assign bus.ex_alu_src_o      = alu_src_q;
  assign bus.ex_branch_o       = branch_q;
  assign bus.ex_alu_op_o       = alu_op_q;
  assign bus.ex_funct_o        = funct_q;
  assign bus.ex_pc4_o          = pc4_q;
  assign bus.ex_rd1_o          = rd1_q;
  assign bus.ex_rd2_o          = rd2_q;
  assign bus.ex_imm_o          = imm_q;
  assign bus.ex_rs_o           = rs_q;
  assign bus.ex_rt_o           = rt_q;
  assign bus.ex_rt_extra_o     = rt_extra_q;
  assign bus.ex_rd_o           = rd_q;
  assign bus.load_use_hazard_o = hazard;
  assign bubble_cnt_o          = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed and randomized stimulus for id_ex_pipe_reg (bubble counter set to
// 4 bits so saturation is reachable). Expected values come from a reference
// model that holds the EX entry as a struct and applies the pipeline rules
// directly: a bubble clears the control fields, a load copies the ID entry.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int CNT_W = 4;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        branch;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rt_extra;
    logic [4:0]  rd;
  } entry_t;

  logic clk;
  logic rst_n;
  logic stall_i;
  logic flush_i;
  logic cnt_clr_i;
  logic [CNT_W-1:0] bubble_cnt_o;

  id_ex_pipe_reg_if bus ();

  id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .cnt_clr_i    (cnt_clr_i),
    .bus          (bus),
    .bubble_cnt_o (bubble_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  entry_t exp_e;
  int     exp_cnt;
  logic [31:0] cnt_snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the model's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t zero_entry();
    entry_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Hazard derived from the model's EX entry and the current ID inputs.
  function automatic logic model_hazard();
    return exp_e.valid && bus.id_valid_i && exp_e.m[1] && (exp_e.rt != 5'd0) &&
           ((exp_e.rt == bus.id_rs_i) || (exp_e.rt == bus.id_rt_i));
  endfunction

  task automatic check_all(input string pfx);
    checkOutput({pfx, ".valid"},    64'(bus.ex_valid_o),    64'(exp_e.valid));
    checkOutput({pfx, ".wb"},       64'(bus.ex_wb_ctrl_o),  64'(exp_e.wb));
    checkOutput({pfx, ".m"},        64'(bus.ex_m_ctrl_o),   64'(exp_e.m));
    checkOutput({pfx, ".reg_dst"},  64'(bus.ex_reg_dst_o),  64'(exp_e.reg_dst));
    checkOutput({pfx, ".alu_op"},   64'(bus.ex_alu_op_o),   64'(exp_e.alu_op));
    checkOutput({pfx, ".alu_src"},  64'(bus.ex_alu_src_o),  64'(exp_e.alu_src));
    checkOutput({pfx, ".branch"},   64'(bus.ex_branch_o),   64'(exp_e.branch));
    checkOutput({pfx, ".funct"},    64'(bus.ex_funct_o),    64'(exp_e.funct));
    checkOutput({pfx, ".pc4"},      64'(bus.ex_pc4_o),      64'(exp_e.pc4));
    checkOutput({pfx, ".rd1"},      64'(bus.ex_rd1_o),      64'(exp_e.rd1));
    checkOutput({pfx, ".rd2"},      64'(bus.ex_rd2_o),      64'(exp_e.rd2));
    checkOutput({pfx, ".imm"},      64'(bus.ex_imm_o),      64'(exp_e.imm));
    checkOutput({pfx, ".rs"},       64'(bus.ex_rs_o),       64'(exp_e.rs));
    checkOutput({pfx, ".rt"},       64'(bus.ex_rt_o),       64'(exp_e.rt));
    checkOutput({pfx, ".rt_extra"}, 64'(bus.ex_rt_extra_o), 64'(exp_e.rt_extra));
    checkOutput({pfx, ".rd"},       64'(bus.ex_rd_o),       64'(exp_e.rd));
    checkOutput({pfx, ".cnt"},      64'(bubble_cnt_o),      64'(exp_cnt));
  endtask

  // One clock: check hazard before the edge, advance the model, check after.
  task automatic applyStimulus(input string pfx);
    logic   haz;
    logic   bub;
    entry_t nxt;
    #1;
    haz = model_hazard();
    checkOutput({pfx, ".hazard"}, 64'(bus.load_use_hazard_o), 64'(haz));
    @(posedge clk);
    bub = flush_i || (!stall_i && haz);
    if (bub) begin
      exp_e.valid   = 1'b0;
      exp_e.wb      = '0;
      exp_e.m       = '0;
      exp_e.reg_dst = 1'b0;
      exp_e.alu_op  = '0;
      exp_e.alu_src = 1'b0;
      exp_e.branch  = 1'b0;
    end else if (!stall_i) begin
      nxt.valid    = bus.id_valid_i;
      nxt.wb       = bus.id_wb_ctrl_i;
      nxt.m        = bus.id_m_ctrl_i;
      nxt.reg_dst  = bus.id_ex_ctrl_i[0];
      nxt.alu_op   = bus.id_ex_ctrl_i[2:1];
      nxt.alu_src  = bus.id_ex_ctrl_i[3];
      nxt.branch   = bus.id_branch_i;
      nxt.funct    = bus.id_imm_i[5:0];
      nxt.pc4      = bus.id_pc4_i;
      nxt.rd1      = bus.id_rd1_i;
      nxt.rd2      = bus.id_rd2_i;
      nxt.imm      = bus.id_imm_i;
      nxt.rs       = bus.id_rs_i;
      nxt.rt       = bus.id_rt_i;
      nxt.rt_extra = bus.id_rt_extra_i;
      nxt.rd       = bus.id_rd_i;
      exp_e = nxt;
    end
    if (cnt_clr_i) exp_cnt = 0;
    else if (bub && exp_cnt < (1 << CNT_W) - 1) exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check_all(pfx);
  endtask

  task automatic set_id(input logic valid, input logic [1:0] m, input logic [3:0] exc,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt);
    bus.id_valid_i    = valid;
    bus.id_wb_ctrl_i  = 2'b01;
    bus.id_m_ctrl_i   = m;
    bus.id_ex_ctrl_i  = exc;
    bus.id_branch_i   = 1'b0;
    bus.id_pc4_i      = $urandom;
    bus.id_rd1_i      = $urandom;
    bus.id_rd2_i      = $urandom;
    bus.id_imm_i      = imm;
    bus.id_rs_i       = rs;
    bus.id_rt_i       = rt;
    bus.id_rt_extra_i = 5'($urandom_range(0, 31));
    bus.id_rd_i       = 5'($urandom_range(0, 31));
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
    set_id(1'b0, 2'b00, 4'b0000, 32'd0, 5'd0, 5'd0);
    exp_e = zero_entry();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Plain load
    set_id(1'b1, 2'b00, 4'b1011, 32'h0000_0020, 5'd3, 5'd4);
    applyStimulus("plain");
    checkOutput("plain.alu_src_k", 64'(bus.ex_alu_src_o), 64'd1);
    checkOutput("plain.alu_op_k",  64'(bus.ex_alu_op_o),  64'd1);
    checkOutput("plain.reg_dst_k", 64'(bus.ex_reg_dst_o), 64'd1);
    checkOutput("plain.funct_k",   64'(bus.ex_funct_o),   64'h20);
    checkOutput("plain.valid_k",   64'(bus.ex_valid_o),   64'd1);

    // Load-use: lw rt=5 in EX, ID reads rs=5
    set_id(1'b1, 2'b10, 4'b1000, 32'd4, 5'd1, 5'd5);
    applyStimulus("lw");
    set_id(1'b1, 2'b00, 4'b0101, 32'h22, 5'd5, 5'd7);
    #1;
    checkOutput("lu.hazard_k", 64'(bus.load_use_hazard_o), 64'd1);
    cnt_snap = 32'(bubble_cnt_o);
    applyStimulus("lu.bubble");
    checkOutput("lu.valid_k", 64'(bus.ex_valid_o), 64'd0);
    checkOutput("lu.cnt_k",   64'(bubble_cnt_o),   64'(cnt_snap + 1));
    #1;
    checkOutput("lu.hazard_clr_k", 64'(bus.load_use_hazard_o), 64'd0);
    applyStimulus("lu.load");
    checkOutput("lu.rs_k", 64'(bus.ex_rs_o), 64'd5);

    // lw writing $zero never raises a hazard
    set_id(1'b1, 2'b10, 4'b1000, 32'd4, 5'd1, 5'd0);
    applyStimulus("lw0");
    set_id(1'b1, 2'b00, 4'b0101, 32'h22, 5'd0, 5'd0);
    #1;
    checkOutput("lw0.hazard_k", 64'(bus.load_use_hazard_o), 64'd0);
    applyStimulus("lw0.next");

    // Stall vs hazard
    set_id(1'b1, 2'b10, 4'b1000, 32'd8, 5'd2, 5'd5);
    applyStimulus("sh.lw");
    set_id(1'b1, 2'b00, 4'b0101, 32'h24, 5'd5, 5'd9);
    stall_i = 1'b1;
    cnt_snap = 32'(bubble_cnt_o);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sh.stall");
      checkOutput("sh.hazard_held_k", 64'(bus.load_use_hazard_o), 64'd1);
      checkOutput("sh.cnt_held_k",    64'(bubble_cnt_o),          64'(cnt_snap));
    end
    stall_i = 1'b0;
    applyStimulus("sh.release");
    checkOutput("sh.cnt_inc_k", 64'(bubble_cnt_o), 64'(cnt_snap + 1));

    // Flush during stall
    set_id(1'b1, 2'b01, 4'b1111, 32'h3f, 5'd6, 5'd7);
    applyStimulus("fs.load");
    set_id(1'b1, 2'b01, 4'b1111, 32'h11, 5'd8, 5'd9);
    stall_i = 1'b1; flush_i = 1'b1;
    applyStimulus("fs.flush");
    checkOutput("fs.rs_k", 64'(bus.ex_rs_o), 64'd6);
    stall_i = 1'b0; flush_i = 1'b0;

    // Counter saturation, then clear beats increment
    flush_i = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus("sat");
    checkOutput("sat.cnt_k", 64'(bubble_cnt_o), 64'hF);
    cnt_clr_i = 1'b1;
    applyStimulus("clr");
    checkOutput("clr.cnt_k", 64'(bubble_cnt_o), 64'd0);
    cnt_clr_i = 1'b0; flush_i = 1'b0;

    // Reset mid-stream, asserted between edges
    set_id(1'b1, 2'b10, 4'b1001, 32'h5, 5'd3, 5'd3);
    bus.id_rd1_i = 32'hDEADBEEF;
    applyStimulus("mr.load");
    flush_i = 1'b1;
    applyStimulus("mr.flush");
    flush_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_e = zero_entry();
    exp_cnt = 0;
    check_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; small specifier range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      bus.id_wb_ctrl_i = 2'($urandom);
      bus.id_branch_i  = 1'($urandom);
      flush_i   = ($urandom_range(0, 7) == 0);
      stall_i   = ($urandom_range(0, 3) == 0);
      cnt_clr_i = ($urandom_range(0, 31) == 0);
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
